fir_serial_host: RTL

FIR_SERIAL_HOST -- requirements
Module: fir_serial_host

---
 rtl/fir_serial_host_if.sv | 30 +++
 rtl/fir_serial_host.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fir_serial_host_if.sv
// rtl/fir_serial_host_if.sv - sample/result stream bundle between the FIR serial host and its user/filter.
interface fir_serial_host_if #(
   parameter int SAMPLE_W = 16,
   parameter int RES_W    = 32
);
   logic [SAMPLE_W-1:0] s_data;
   logic                s_valid;
   logic                s_ready;
   logic                tx_bit;
   logic                tx_frame_start;
   logic                tx_filler;
   logic                rx_dv;
   logic                rx_bit;
   logic [RES_W-1:0]    res_data;
   logic                res_valid;
   logic                res_trunc;
   logic [7:0]          trunc_cnt;

   modport master (
      output s_data, s_valid, rx_dv, rx_bit,
      input  s_ready, tx_bit, tx_frame_start, tx_filler,
      input  res_data, res_valid, res_trunc, trunc_cnt
   );

   modport slave (
      input  s_data, s_valid, rx_dv, rx_bit,
      output s_ready, tx_bit, tx_frame_start, tx_filler,
      output res_data, res_valid, res_trunc, trunc_cnt
   );
endinterface

// File: rtl/fir_serial_host.sv
// rtl/fir_serial_host.sv - serialises samples into fixed frames for the filter and deserialises its results.
module fir_serial_host #(
   parameter int SAMPLE_W = 16,
   parameter int RES_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   fir_serial_host_if.slave   bus
);
   localparam int TXC_W = $clog2(SAMPLE_W);
   localparam int RXC_W = $clog2(RES_W + 1);
   localparam logic [TXC_W-1:0] TX_LAST = TXC_W'(SAMPLE_W - 1);
   localparam logic [RXC_W-1:0] RX_LAST = RXC_W'(RES_W - 1);

   // ---------------- transmitter ----------------
   logic [SAMPLE_W-1:0] sr;
   logic [SAMPLE_W-1:0] buf_data;
   logic                buf_full;
   logic [TXC_W-1:0]    tx_cnt;
   logic                frame_start_q;
   logic                filler_q;
   logic                accept;
   logic                frame_end;

   assign accept    = bus.s_valid & ~buf_full;
   assign frame_end = (tx_cnt == TX_LAST);

   // Frame load sees the buffer as it was before this edge, so a word accepted
   // on the load edge waits in the buffer for the following frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr            <= '0;
         buf_data      <= '0;
         buf_full      <= 1'b0;
         tx_cnt        <= '0;
         frame_start_q <= 1'b0;
         filler_q      <= 1'b0;
      end else begin
         frame_start_q <= frame_end;
         filler_q      <= frame_end & ~buf_full;
         if (frame_end) begin
            tx_cnt <= '0;
            sr     <= buf_full ? buf_data : '0;
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
            sr     <= {sr[SAMPLE_W-2:0], 1'b0};
         end
         if (accept) begin
            buf_data <= bus.s_data;
            buf_full <= 1'b1;
         end else if (frame_end) begin
            buf_full <= 1'b0;
         end
      end
   end

   assign bus.s_ready        = ~buf_full;
   assign bus.tx_bit         = sr[SAMPLE_W-1];
   assign bus.tx_frame_start = frame_start_q;
   assign bus.tx_filler      = filler_q;

   // ---------------- receiver ----------------
   typedef enum logic {RX_IDLE, RX_CAP} rx_state_t;

   rx_state_t        state;
   rx_state_t        state_nx;
   logic [RXC_W-1:0] rx_cnt;
   logic [RES_W-1:0] cap;
   logic [RES_W-1:0] res_data_q;
   logic             res_valid_q;
   logic             res_trunc_q;
   logic [7:0]       trunc_cnt_q;
   logic             cap_shift;
   logic             cap_done;
   logic             cap_abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RX_IDLE;
      else     state <= state_nx;
   end

   // A new rx_dv always restarts capture, even on the edge that would finish a word.
   always_comb begin
      state_nx = state;
      if (bus.rx_dv)
         state_nx = RX_CAP;
      else if (state == RX_CAP && rx_cnt == RX_LAST)
         state_nx = RX_IDLE;
   end

   always_comb begin
      cap_shift = 1'b0;
      cap_done  = 1'b0;
      cap_abort = 1'b0;
      if (state == RX_CAP) begin
         cap_shift = ~bus.rx_dv;
         cap_done  = ~bus.rx_dv & (rx_cnt == RX_LAST);
         cap_abort = bus.rx_dv & (rx_cnt != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_cnt      <= '0;
         cap         <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         res_trunc_q <= 1'b0;
         trunc_cnt_q <= '0;
      end else begin
         res_valid_q <= cap_done;
         res_trunc_q <= cap_abort;
         if (bus.rx_dv) begin
            rx_cnt <= '0;
            cap    <= '0;
         end else if (cap_shift) begin
            rx_cnt <= rx_cnt + 1'b1;
            cap    <= {cap[RES_W-2:0], bus.rx_bit};
         end
         if (cap_done)
            res_data_q <= {cap[RES_W-2:0], bus.rx_bit};
         if (cap_abort && trunc_cnt_q != 8'hFF)
            trunc_cnt_q <= trunc_cnt_q + 1'b1;
      end
   end

   assign bus.res_data  = res_data_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_trunc = res_trunc_q;
   assign bus.trunc_cnt = trunc_cnt_q;
endmodule
